// File: rtl/gvp_program_sequencer.sv
// gvp_program_sequencer: loads a vector program into the GVP over its
// config bus, then releases the GVP and waits for it to finish.
// Optional feature macro: GVP_SEQ_WATCHDOG_EN adds timeout_cycles and a
// RUN-state watchdog that forces GVP reset and enters ERR on expiry.
module gvp_program_sequencer #(
  parameter int          NUM_VECTORS   = 16,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          SETTLE_CYCLES = 12,
  parameter logic [31:0] CTRL_ADDR     = 32'd1,
  parameter logic [31:0] VSET_ADDR     = 32'd4,
  parameter logic [31:0] VPROG_ADDR    = 32'd3
) (
  input  logic         a_clk,
  input  logic         a_resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] preset_data,
  input  logic [511:0] s_vec_tdata,
  input  logic         s_vec_tvalid,
  output logic         s_vec_tready,
  input  logic         s_vec_tlast,
  input  logic         gvp_finished,
  input  logic         gvp_reset_state,
  output logic [31:0]  config_addr,
  output logic [511:0] config_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [7:0]   vec_count
`ifdef GVP_SEQ_WATCHDOG_EN
  ,
  input  logic [31:0]  timeout_cycles
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    NUM_LIM     = 8'(NUM_VECTORS);

  // ST_FORCE performs the GVP-reset write that precedes a forced exit
  // (abort to IDLE, or watchdog expiry to ERR).
  typedef enum logic [3:0] {
    ST_IDLE, ST_RST, ST_SETTLE, ST_LOAD, ST_PRESET,
    ST_RELEASE, ST_RUN, ST_DONE, ST_ERR, ST_FORCE
  } state_t;

  state_t         state, state_n;
  logic [1:0]     rst_sync;
  logic           rst_n;
  logic           wr_busy;
  logic [CW-1:0]  wr_cnt;
  logic [31:0]    wr_addr, wr_addr_n;
  logic [511:0]   wr_data, wr_data_n;
  logic           wr_start, wr_done;
  logic [SW-1:0]  settle_cnt;
  logic           last_pend, last_n;
  logic           force_err, force_err_n;
  logic           vec_clr, vec_inc;
  logic           abort_hit;
`ifdef GVP_SEQ_WATCHDOG_EN
  logic [31:0]    run_cnt;
`endif

  // Reset synchroniser: assert asynchronously, release two edges later.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n   = rst_sync[1];
  // A write spans HOLD_CYCLES presentation cycles plus one gap cycle.
  assign wr_done = wr_busy && (wr_cnt == HOLD_LAST);

  // Output decode: bus driven only during the hold phase of a write.
  always_comb begin
    config_addr  = '0;
    config_data  = '0;
    if (wr_busy && (wr_cnt != HOLD_LAST)) begin
      config_addr = wr_addr;
      config_data = wr_data;
    end
    s_vec_tready = (state == ST_LOAD) && !wr_busy;
    busy         = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    done         = (state == ST_DONE);
    error        = (state == ST_ERR);
  end

  // Next-state logic and write launch requests; abort takes priority.
  always_comb begin
    state_n     = state;
    wr_start    = 1'b0;
    wr_addr_n   = '0;
    wr_data_n   = '0;
    vec_clr     = 1'b0;
    vec_inc     = 1'b0;
    last_n      = last_pend;
    force_err_n = force_err;
    abort_hit   = abort && (state != ST_IDLE) && (state != ST_FORCE);
    if (abort_hit) begin
      wr_start    = 1'b1;
      wr_addr_n   = CTRL_ADDR;
      wr_data_n   = 512'd1;
      force_err_n = 1'b0;
      last_n      = 1'b0;
      state_n     = ST_FORCE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            wr_start  = 1'b1;
            wr_addr_n = CTRL_ADDR;
            wr_data_n = 512'd1;
            vec_clr   = 1'b1;
            last_n    = 1'b0;
            state_n   = ST_RST;
          end
        end
        ST_RST: if (wr_done) state_n = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_n = ST_LOAD;
        ST_LOAD: begin
          if (wr_done && last_pend) begin
            wr_start  = 1'b1;
            wr_addr_n = VSET_ADDR;
            wr_data_n = preset_data;
            last_n    = 1'b0;
            state_n   = ST_PRESET;
          end else if (s_vec_tvalid && s_vec_tready) begin
            if (vec_count == NUM_LIM) begin
              state_n = ST_ERR;
            end else begin
              wr_start  = 1'b1;
              wr_addr_n = VPROG_ADDR;
              wr_data_n = s_vec_tdata;
              vec_inc   = 1'b1;
              last_n    = s_vec_tlast;
            end
          end
        end
        ST_PRESET: begin
          if (wr_done) begin
            wr_start  = 1'b1;
            wr_addr_n = CTRL_ADDR;
            wr_data_n = '0;
            state_n   = ST_RELEASE;
          end
        end
        ST_RELEASE: if (wr_done) state_n = ST_RUN;
        ST_RUN: begin
          if (gvp_finished && !gvp_reset_state) begin
            state_n = ST_DONE;
          end
`ifdef GVP_SEQ_WATCHDOG_EN
          else if ((timeout_cycles != '0) && (run_cnt == timeout_cycles - 32'd1)) begin
            wr_start    = 1'b1;
            wr_addr_n   = CTRL_ADDR;
            wr_data_n   = 512'd1;
            force_err_n = 1'b1;
            state_n     = ST_FORCE;
          end
`endif
        end
        ST_FORCE: begin
          if (abort) force_err_n = 1'b0;
          if (wr_done) state_n = (force_err && !abort) ? ST_ERR : ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, write engine and counters.
  always_ff @(posedge a_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_busy    <= 1'b0;
      wr_cnt     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      settle_cnt <= '0;
      last_pend  <= 1'b0;
      force_err  <= 1'b0;
      vec_count  <= '0;
    end else begin
      state     <= state_n;
      last_pend <= last_n;
      force_err <= force_err_n;
      if (wr_start) begin
        wr_busy <= 1'b1;
        wr_cnt  <= '0;
        wr_addr <= wr_addr_n;
        wr_data <= wr_data_n;
      end else if (wr_busy) begin
        if (wr_cnt == HOLD_LAST) wr_busy <= 1'b0;
        else                     wr_cnt  <= wr_cnt + 1'b1;
      end
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (vec_clr)                            vec_count <= '0;
      else if (vec_inc && vec_count < NUM_LIM) vec_count <= vec_count + 8'd1;
    end
  end

`ifdef GVP_SEQ_WATCHDOG_EN
  // Watchdog: counts cycles spent in RUN.
  always_ff @(posedge a_clk or negedge rst_n) begin
    if (!rst_n) run_cnt <= '0;
    else        run_cnt <= (state == ST_RUN) ? run_cnt + 32'd1 : '0;
  end
`endif

endmodule

// File: tb/tb_gvp_program_sequencer.sv
// Randomised self-checking bench for gvp_program_sequencer. A bus monitor
// decodes config writes; expected write lists are built from stimulus.
// Define GVP_SEQ_WATCHDOG_EN for both files to exercise the watchdog.
module tb_gvp_program_sequencer;

  localparam int          NV = 16;
  localparam int          HC = 4;
  localparam int          SC = 12;
  localparam logic [31:0] CA = 32'd1;
  localparam logic [31:0] VA = 32'd4;
  localparam logic [31:0] PA = 32'd3;

  logic         a_clk, a_resetn, start, abort;
  logic [511:0] preset_data, s_vec_tdata, config_data;
  logic         s_vec_tvalid, s_vec_tready, s_vec_tlast;
  logic         gvp_finished, gvp_reset_state;
  logic [31:0]  config_addr;
  logic         busy, done, error;
  logic [7:0]   vec_count;
`ifdef GVP_SEQ_WATCHDOG_EN
  logic [31:0]  timeout_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  gvp_program_sequencer #(
    .NUM_VECTORS(NV), .HOLD_CYCLES(HC), .SETTLE_CYCLES(SC),
    .CTRL_ADDR(CA), .VSET_ADDR(VA), .VPROG_ADDR(PA)
  ) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .start(start), .abort(abort),
    .preset_data(preset_data), .s_vec_tdata(s_vec_tdata),
    .s_vec_tvalid(s_vec_tvalid), .s_vec_tready(s_vec_tready),
    .s_vec_tlast(s_vec_tlast), .gvp_finished(gvp_finished),
    .gvp_reset_state(gvp_reset_state), .config_addr(config_addr),
    .config_data(config_data), .busy(busy), .done(done), .error(error),
    .vec_count(vec_count)
`ifdef GVP_SEQ_WATCHDOG_EN
    , .timeout_cycles(timeout_cycles)
`endif
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    int           len;
    int           gap;
  } wr_t;

  wr_t obs[$];
  wr_t cur;
  bit  in_wr = 0;
  int  zero_run = 0;

  // Bus monitor: one record per write with its hold length and preceding idle cycles.
  always @(negedge a_clk) begin
    if (config_addr != 32'd0) begin
      if (in_wr && (config_addr != cur.addr || config_data != cur.data)) begin
        obs.push_back(cur);
        cur.addr = config_addr; cur.data = config_data; cur.len = 1; cur.gap = 0;
      end else if (in_wr) begin
        cur.len++;
      end else begin
        in_wr = 1;
        cur.addr = config_addr; cur.data = config_data; cur.len = 1; cur.gap = zero_run;
      end
      zero_run = 0;
    end else begin
      if (in_wr) begin
        obs.push_back(cur);
        in_wr = 0;
      end
      zero_run++;
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic last);
    int c;
    bit ok;
    s_vec_tvalid = 1'b1; s_vec_tdata = d; s_vec_tlast = last;
    ok = 0; c = 0;
    while (!ok && c < 200) begin
      @(negedge a_clk);
      if (s_vec_tready) begin
        @(posedge a_clk); #1;
        ok = 1;
      end
      c++;
    end
    s_vec_tvalid = 1'b0; s_vec_tlast = 1'b0;
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (obs.size() < n && c < budget) begin
      @(posedge a_clk);
      c++;
    end
    #1;
    if (obs.size() < n) check("write_wait_timeout", obs.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    if (busy) check("idle_wait_timeout", busy, 0);
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] a,
                             input logic [511:0] d);
    if (i < obs.size()) begin
      check({tag, "_addr"}, obs[i].addr, a);
      check({tag, "_data"}, obs[i].data, d);
      check({tag, "_len"}, obs[i].len, HC);
    end else begin
      check({tag, "_missing"}, obs.size(), i + 1);
    end
  endtask

  // Full program: CTRL(1), VPROG per beat, VSET(preset), CTRL(0), then RUN to DONE.
  task automatic run_program(input int n, input int fin_delay, input bit spurious);
    logic [31:0]  ea[$];
    logic [511:0] ed[$];
    logic [511:0] d;
    obs.delete();
    preset_data = rand512();
    ea.push_back(CA); ed.push_back(512'd1);
    do_start();
    check("start_busy", busy, 1);
    check("start_vec_clr", vec_count, 0);
    for (int i = 0; i < n; i++) begin
      d = rand512();
      if (i > 0) tick($urandom_range(0, 3));
      send_beat(d, (i == n - 1));
      ea.push_back(PA); ed.push_back(d);
      if (spurious && i == 0) begin
        start = 1'b1; tick(1); start = 1'b0;
      end
    end
    ea.push_back(VA); ed.push_back(preset_data);
    ea.push_back(CA); ed.push_back('0);
    wait_writes(n + 3, 3000);
    check("prog_nwrites", obs.size(), n + 3);
    for (int i = 0; i < ea.size(); i++) check_write($sformatf("prog_w%0d", i), i, ea[i], ed[i]);
    if (obs.size() > 1) check("settle_gap", obs[1].gap, SC + 2);
    if (obs.size() > n + 2) check("release_gap", obs[n+2].gap, 1);
    tick(fin_delay);
    gvp_finished = 1'b1; gvp_reset_state = 1'b1;
    tick(3);
    check("run_waits_reset_state", done, 0);
    check("run_busy", busy, 1);
    gvp_reset_state = 1'b0;
    tick(1);
    gvp_finished = 1'b0;
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_vec_count", vec_count, n);
    check("done_error", error, 0);
    tick(3);
    check("done_holds", done, 1);
    check("done_bus_idle", config_addr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    a_resetn = 1'b0; start = 1'b0; abort = 1'b0;
    preset_data = '0; s_vec_tdata = '0; s_vec_tvalid = 1'b0; s_vec_tlast = 1'b0;
    gvp_finished = 1'b0; gvp_reset_state = 1'b0;
`ifdef GVP_SEQ_WATCHDOG_EN
    timeout_cycles = '0;
`endif
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_addr", config_addr, 0);
    check("rst_data", config_data, 0);
    check("rst_tready", s_vec_tready, 0);
    a_resetn = 1'b1;
    tick(3);

    // Programs of varying length, including the full-capacity boundary.
    run_program(3, 100, 1);
    run_program(NV, $urandom_range(0, 20), 0);
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, NV);
      run_program(n, $urandom_range(0, 20), 0);
    end

    // Overflow: 17 beats without tlast.
    obs.delete();
    do_start();
    for (int i = 0; i <= NV; i++) send_beat(rand512(), 1'b0);
    tick(2);
    check("ovf_nwrites", obs.size(), NV + 1);
    for (int i = 1; i < obs.size(); i++) check($sformatf("ovf_w%0d_addr", i), obs[i].addr, PA);
    check("ovf_error", error, 1);
    check("ovf_busy", busy, 0);
    check("ovf_vec_count", vec_count, NV);
    tick(5);
    check("err_addr", config_addr, 0);
    check("err_data", config_data, 0);
    check("err_holds", error, 1);
    abort = 1'b1;
    tick(1);
    wait_idle(40);
    abort = 1'b0;
    check("err_abort_nwrites", obs.size(), NV + 2);
    check_write("err_abort_ctrl", NV + 1, CA, 512'd1);
    check("err_abort_error", error, 0);

    // Abort mid-LOAD while the second beat is presented.
    obs.delete();
    do_start();
    begin
      logic [511:0] d1, d2;
      d1 = rand512(); d2 = rand512();
      send_beat(d1, 1'b0);
      tick(2);
      s_vec_tvalid = 1'b1; s_vec_tdata = d2;
      abort = 1'b1;
      tick(1);
      wait_idle(40);
      abort = 1'b0; s_vec_tvalid = 1'b0;
      check("abort_nwrites", obs.size(), 3);
      if (obs.size() > 1) check("abort_vprog_data", obs[1].data, d1);
      check_write("abort_ctrl", 2, CA, 512'd1);
      if (obs.size() > 2) check("abort_no_gap", obs[2].gap, 0);
      check("abort_busy", busy, 0);
      check("abort_tready", s_vec_tready, 0);
    end

    // Asynchronous reset during RUN, then synchronised release.
    obs.delete();
    do_start();
    send_beat(rand512(), 1'b1);
    wait_writes(4, 500);
    tick(5);
    check("pre_reset_busy", busy, 1);
    @(negedge a_clk); #2;
    a_resetn = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_addr", config_addr, 0);
    check("areset_data", config_data, 0);
    check("areset_vec_count", vec_count, 0);
    check("areset_tready", s_vec_tready, 0);
    check("areset_done_err", {done, error}, 0);
    @(posedge a_clk); #3;
    a_resetn = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_ignored_edge1", busy, 0);
    tick(3);
    do_start();
    check("start_after_sync", busy, 1);
    abort = 1'b1;
    tick(1);
    wait_idle(40);
    abort = 1'b0;

`ifdef GVP_SEQ_WATCHDOG_EN
    // Watchdog expiry in RUN with no finish.
    timeout_cycles = 32'd50;
    obs.delete();
    do_start();
    send_beat(rand512(), 1'b1);
    wait_writes(5, 1000);
    check_write("wdog_ctrl", 4, CA, 512'd1);
    if (obs.size() > 4) check("wdog_gap", obs[4].gap, 51);
    tick(1);
    check("wdog_error", error, 1);
    timeout_cycles = '0;
    do_start();
    check("wdog_restart", busy, 1);
    abort = 1'b1;
    tick(1);
    wait_idle(40);
    abort = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
